// File: rtl/lane_chain_scheduler.sv
// lane_chain_scheduler
// Shares one fixed-latency 2-bit processing chain among NREQ requesters.
// Requesters are served round-robin with one issue per cycle. Each requester
// may have at most MAX_OUT symbols outstanding. A {valid, id} tag travels
// alongside each symbol so that the chain result comes back tagged with the
// requester that issued it. A small FSM sequences enable and flush/drain.
module lane_chain_scheduler #(
    parameter int NREQ    = 6,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2,
    parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 flush_req,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 chain_in_vld,
    output logic [1:0]           chain_in_data,
    input  logic [1:0]           chain_out_data,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [1:0]           rsp_data,
    output logic                 busy,
    output logic                 flush_done
);

    localparam int CW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_flush_done_nxt;
    logic [IDW-1:0]       r_ptr;
    logic [CW-1:0]        r_cnt [NREQ];
    logic [DEPTH:0]       r_tag_vld;
    logic [DEPTH:0][IDW-1:0] r_tag_id;
    logic                 r_chain_in_vld;
    logic [1:0]           r_chain_in_data;
    logic                 r_rsp_valid;
    logic [IDW-1:0]       r_rsp_id;
    logic [1:0]           r_rsp_data;
    logic                 r_flush_done;
    logic                 w_grant_found;
    logic [IDW-1:0]       w_grant_id;
    logic                 w_accept;
    logic [NREQ-1:0]      w_grant;
    logic [NREQ-1:0]      w_inc;
    logic [NREQ-1:0]      w_dec;
    logic                 w_inflight;

    // Index ptr+off folded back into 0..NREQ-1.
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end else begin
            s = s;
        end
        return IDW'(s);
    endfunction

    // Round-robin search: first requester at or after ptr that is valid and under its credit limit.
    always_comb begin
        logic [IDW-1:0] idx;
        logic           elig;
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        idx           = '0;
        elig          = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            idx           = wrap_idx(r_ptr, off);
            elig          = req_valid[idx] && (r_cnt[idx] < CW'(MAX_OUT));
            w_grant_id    = (!w_grant_found && elig) ? idx : w_grant_id;
            w_grant_found = w_grant_found | elig;
        end
    end

    assign w_accept   = (r_state == ST_RUN) && w_grant_found;
    assign w_grant    = w_accept ? ({{(NREQ-1){1'b0}}, 1'b1} << w_grant_id) : {NREQ{1'b0}};
    assign req_ready  = w_grant;
    assign w_inflight = |r_tag_vld;

    // Per-requester credit up/down events for this cycle.
    always_comb begin
        w_inc = w_grant;
        w_dec = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_dec[i] = r_tag_vld[DEPTH] && (r_tag_id[DEPTH] == IDW'(i));
        end
    end

    // Sequencing FSM next-state and flush_done decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_flush_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && !flush_req) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush_req || !enable) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!w_inflight) begin
                    w_state_nxt      = ST_IDLE;
                    w_flush_done_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register and flush_done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_done <= w_flush_done_nxt;
        end
    end

    // Round-robin pointer moves past the winner only when a grant is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_grant_id == IDW'(NREQ - 1)) ? '0 : (w_grant_id + IDW'(1));
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Issue register to the chain; data holds its last value between issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain_in_vld  <= 1'b0;
            r_chain_in_data <= 2'b00;
        end else begin
            r_chain_in_vld  <= w_accept;
            r_chain_in_data <= w_accept ? req_data[2*w_grant_id +: 2] : r_chain_in_data;
        end
    end

    // Tag pipeline; stage 0 lines up with chain_in, stage DEPTH with chain_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_vld <= {r_tag_vld[DEPTH-1:0], w_accept};
            r_tag_id  <= {r_tag_id[DEPTH-1:0], (w_accept ? w_grant_id : {IDW{1'b0}})};
        end
    end

    // Response register: capture chain result with the tag leaving the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= 2'b00;
        end else begin
            r_rsp_valid <= r_tag_vld[DEPTH];
            r_rsp_id    <= r_tag_vld[DEPTH] ? r_tag_id[DEPTH] : r_rsp_id;
            r_rsp_data  <= r_tag_vld[DEPTH] ? chain_out_data : r_rsp_data;
        end
    end

    // Outstanding-symbol credits; simultaneous accept and response cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end else if (!w_inc[i] && w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] - CW'(1);
                end else begin
                    r_cnt[i] <= r_cnt[i];
                end
            end
        end
    end

    assign chain_in_vld  = r_chain_in_vld;
    assign chain_in_data = r_chain_in_data;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_rsp_id;
    assign rsp_data      = r_rsp_data;
    assign busy          = (r_state != ST_IDLE);
    assign flush_done    = r_flush_done;

endmodule

// File: tb/tb_lane_chain_scheduler.sv
// Bench for lane_chain_scheduler: a behavioural chain (fixed delay plus a
// transform), an independent arbiter/credit/FSM model, and a scoreboard of
// expected responses with their due cycles.
module tb_lane_chain_scheduler;

    localparam int NREQ    = 6;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;
    localparam int IDW     = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 enable;
    logic                 flush_req;
    logic [NREQ-1:0]      req_valid;
    logic [2*NREQ-1:0]    req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 chain_in_vld;
    logic [1:0]           chain_in_data;
    logic [1:0]           chain_out_data;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [1:0]           rsp_data;
    logic                 busy;
    logic                 flush_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [1:0]     data;
        int             due;
    } sb_t;
    sb_t sb[$];

    typedef enum int {M_IDLE, M_RUN, M_DRAIN} mstate_t;
    mstate_t    m_state;
    int         m_ptr;
    int         m_cnt [NREQ];
    logic       m_cin_vld;
    logic [1:0] m_cin_data;
    logic       m_flush_done;

    logic [1:0] pipe [DEPTH];

    lane_chain_scheduler #(
        .NREQ(NREQ), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .IDW(IDW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush_req(flush_req),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .chain_in_vld(chain_in_vld), .chain_in_data(chain_in_data),
        .chain_out_data(chain_out_data), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy), .flush_done(flush_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [1:0] chain_fn(input logic [1:0] x);
        return x + 2'd1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Behavioural shared chain: DEPTH-cycle delay of chain_fn(chain_in_data).
    always @(posedge clk) begin
        pipe[0] <= chain_fn(chain_in_data);
        for (int j = 1; j < DEPTH; j++) pipe[j] <= pipe[j-1];
    end
    assign chain_out_data = pipe[DEPTH-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model and scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        logic            found;
        int              gid;
        int              idx;
        sb_t             e;
        if (!rst_n) begin
            m_state = M_IDLE;
            m_ptr   = 0;
            for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
            sb.delete();
            m_cin_vld    = 1'b0;
            m_cin_data   = 2'b00;
            m_flush_done = 1'b0;
        end else begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("rsp_id", 32'(rsp_id), 32'(e.id));
                    check_eq("rsp_data", 32'(rsp_data), 32'(e.data));
                    check_eq("rsp_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                check_eq("rsp_missing", 32'(rsp_valid), 32'd1);
                void'(sb.pop_front());
            end

            check_eq("busy", 32'(busy), 32'(m_state != M_IDLE));
            check_eq("flush_done", 32'(flush_done), 32'(m_flush_done));
            check_eq("chain_in_vld", 32'(chain_in_vld), 32'(m_cin_vld));
            if (m_cin_vld) check_eq("chain_in_data", 32'(chain_in_data), 32'(m_cin_data));

            exp_ready = '0;
            found     = 1'b0;
            gid       = 0;
            if (m_state == M_RUN) begin
                for (int off = 0; off < NREQ; off++) begin
                    idx = (m_ptr + off) % NREQ;
                    if (!found && req_valid[idx] && m_cnt[idx] < MAX_OUT) begin
                        found = 1'b1;
                        gid   = idx;
                    end
                end
            end
            if (found) exp_ready[gid] = 1'b1;
            check_eq("req_ready", 32'(req_ready), 32'(exp_ready));

            m_cin_vld = found;
            if (found) begin
                m_cin_data = req_data[2*gid +: 2];
                sb.push_back('{id: IDW'(gid), data: chain_fn(req_data[2*gid +: 2]), due: cyc + DEPTH + 2});
                m_cnt[gid]++;
                m_ptr = (gid + 1) % NREQ;
            end
            if (sb.size() > 0 && sb[0].due == cyc + 1) m_cnt[sb[0].id]--;

            m_flush_done = 1'b0;
            case (m_state)
                M_IDLE:  if (enable && !flush_req) m_state = M_RUN;
                M_RUN:   if (flush_req || !enable) m_state = M_DRAIN;
                M_DRAIN: if (sb.size() == 0) begin m_state = M_IDLE; m_flush_done = 1'b1; end
                default: m_state = M_IDLE;
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_one(input int id, input logic [1:0] d);
        logic got;
        got = 1'b0;
        req_data[2*id +: 2] = d;
        req_valid[id] = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
        end
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        check_eq("accept_seen", 32'(got), 32'd1);
    endtask

    initial begin
        int fd_cnt;
        rst_n     = 1'b0;
        enable    = 1'b0;
        flush_req = 1'b0;
        req_valid = '0;
        req_data  = '0;
        #12;
        check_eq("rst_chain_in_vld", 32'(chain_in_vld), 32'd0);
        check_eq("rst_chain_in_data", 32'(chain_in_data), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_flush_done", 32'(flush_done), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);

        // Single symbol from requester 0, latency check via scoreboard due cycle.
        enable = 1'b1;
        send_one(0, 2'b10);
        tick(12);

        // All requesters valid: strict rotation, responses in issue order.
        req_valid = '1;
        for (int c = 0; c < 36; c++) begin
            req_data = 12'($urandom);
            tick(1);
        end
        req_valid = '0;
        tick(12);

        // Only requester 3: credit limit stalls, then accept and response share edges.
        req_valid = 6'b001000;
        for (int c = 0; c < 24; c++) begin
            req_data = 12'($urandom);
            tick(1);
        end
        req_valid = '0;
        tick(12);

        // Flush with three symbols in flight.
        req_valid = '1;
        tick(2);
        flush_req = 1'b1;
        tick(1);
        fd_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (flush_done) fd_cnt++;
        end
        check_eq("flush_done_count", 32'(fd_cnt), 32'd1);
        check_eq("busy_after_flush", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        req_valid = '0;
        tick(4);

        // Asynchronous reset with symbols in flight.
        req_valid = '1;
        tick(4);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_chain_in_vld", 32'(chain_in_vld), 32'd0);
        check_eq("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        tick(2);
        rst_n = 1'b1;
        tick(15);
        req_valid = 6'b000100;
        tick(3);
        req_valid = '0;
        tick(12);

        enable = 1'b0;
        tick(10);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
